// File: rtl/pwm_mixer_dsm.sv
// Time-multiplexed NCH-channel audio mixer with per-channel gain, master attenuation,
// output saturation and a first-order delta-sigma 1-bit DAC.
module pwm_mixer_dsm #(
  parameter int NCH = 8,
  parameter int W   = 16,
  parameter int GW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_stb,
  input  logic [NCH*W-1:0]  ch_data,
  input  logic [NCH-1:0]    ch_active,
  input  logic [NCH*GW-1:0] ch_gain,
  input  logic [2:0]        master_shift,
  output logic              busy,
  output logic [W-1:0]      mixed,
  output logic              mixed_valid,
  output logic              clip,
  output logic              pwm_out
);

  localparam int IW = $clog2(NCH);
  localparam int AW = W + GW + $clog2(NCH) + 1;
  localparam int PW = W + GW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SCALE} state_t;

  // Gain-weighted sample, floored by the unity-gain shift and sign-extended to acc width.
  function automatic logic signed [AW-1:0] weigh(input logic signed [W-1:0] x,
                                                 input logic [GW-1:0] g);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ge;
    logic signed [PW-1:0] p;
    xe = PW'(x);
    ge = PW'($signed({1'b0, g}));
    p  = xe * ge;
    return AW'(p >>> (GW - 1));
  endfunction

  // Returns {clip, value}: attenuated accumulator clamped to the W-bit signed range.
  function automatic logic [W:0] saturate(input logic signed [AW-1:0] a,
                                          input logic [2:0] sh);
    logic signed [AW-1:0] s;
    s = a >>> sh;
    if (s > SAT_MAX)      return {1'b1, SAT_MAX[W-1:0]};
    else if (s < SAT_MIN) return {1'b1, SAT_MIN[W-1:0]};
    else                  return {1'b0, s[W-1:0]};
  endfunction

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [W-1:0]   mixed_q, mixed_d;
  logic                  clip_q, clip_d;
  logic                  mixed_valid_q, mixed_valid_d;
  logic [W-1:0]          dsm_q, dsm_d;
  logic                  pwm_q, pwm_d;

  logic signed [W-1:0]   data_s_q [NCH];
  logic signed [W-1:0]   data_s_d [NCH];
  logic [GW-1:0]         gain_s_q [NCH];
  logic [GW-1:0]         gain_s_d [NCH];
  logic [NCH-1:0]        active_s_q, active_s_d;

  logic                  load;
  logic [W:0]            sat;
  logic [W-1:0]          dsm_u;
  logic [W:0]            dsm_sum;

  // Control FSM and accumulator
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    mixed_d       = mixed_q;
    clip_d        = clip_q;
    mixed_valid_d = 1'b0;
    load          = 1'b0;
    sat           = '0;
    case (state_q)
      S_IDLE: begin
        if (sample_stb) begin
          load    = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (active_s_q[idx_q]) acc_d = acc_q + weigh(data_s_q[idx_q], gain_s_q[idx_q]);
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) state_d = S_SCALE;
      end
      S_SCALE: begin
        sat           = saturate(acc_q, master_shift);
        mixed_d       = sat[W-1:0];
        clip_d        = sat[W];
        mixed_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Input snapshot so sources may change once the pass has started
  always_comb begin
    active_s_d = load ? ch_active : active_s_q;
    for (int i = 0; i < NCH; i++) begin
      data_s_d[i] = load ? ch_data[i*W +: W]  : data_s_q[i];
      gain_s_d[i] = load ? ch_gain[i*GW +: GW] : gain_s_q[i];
    end
  end

  // Delta-sigma: offset-binary input, carry out of the W-bit accumulator is the bit
  always_comb begin
    dsm_u   = {~mixed_q[W-1], mixed_q[W-2:0]};
    dsm_sum = {1'b0, dsm_q} + {1'b0, dsm_u};
    dsm_d   = dsm_sum[W-1:0];
    pwm_d   = dsm_sum[W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      mixed_q       <= '0;
      clip_q        <= 1'b0;
      mixed_valid_q <= 1'b0;
      dsm_q         <= '0;
      pwm_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      mixed_q       <= mixed_d;
      clip_q        <= clip_d;
      mixed_valid_q <= mixed_valid_d;
      dsm_q         <= dsm_d;
      pwm_q         <= pwm_d;
    end
  end

  always_ff @(posedge clk) begin
    active_s_q <= active_s_d;
    for (int i = 0; i < NCH; i++) begin
      data_s_q[i] <= data_s_d[i];
      gain_s_q[i] <= gain_s_d[i];
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign mixed       = mixed_q;
  assign mixed_valid = mixed_valid_q;
  assign clip        = clip_q;
  assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_pwm_mixer_dsm.sv
// Scoreboard bench for pwm_mixer_dsm: stimulus pushes model results, a monitor pops
// them on every mixed_valid; directed timing, reset and delta-sigma density checks.
module tb_pwm_mixer_dsm;
  localparam int NCH = 8;
  localparam int W   = 16;
  localparam int GW  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_stb = 1'b0;
  logic [NCH*W-1:0]  ch_data = '0;
  logic [NCH-1:0]    ch_active = '0;
  logic [NCH*GW-1:0] ch_gain = '0;
  logic [2:0]        master_shift = '0;
  logic              busy, mixed_valid, clip, pwm_out;
  logic [W-1:0]      mixed;

  always #5 clk = ~clk;

  pwm_mixer_dsm #(.NCH(NCH), .W(W), .GW(GW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .ch_data(ch_data),
    .ch_active(ch_active), .ch_gain(ch_gain), .master_shift(master_shift),
    .busy(busy), .mixed(mixed), .mixed_valid(mixed_valid), .clip(clip), .pwm_out(pwm_out)
  );

  typedef struct packed { logic [W-1:0] m; logic c; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   valid_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Floor division for signed values (longint '/' truncates toward zero).
  function automatic longint fdiv(input longint n, input longint dv);
    longint q;
    q = n / dv;
    if ((n % dv) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(input logic [NCH*W-1:0] d, input logic [NCH-1:0] a,
                                 input logic [NCH*GW-1:0] g, input logic [2:0] sh);
    longint sum, s, x, gg, hi, lo;
    exp_t   e;
    sum = 0;
    hi  = (longint'(1) << (W-1)) - 1;
    lo  = -(longint'(1) << (W-1));
    for (int ch = 0; ch < NCH; ch++) begin
      if (a[ch]) begin
        x   = longint'($signed(d[ch*W +: W]));
        gg  = longint'(g[ch*GW +: GW]);
        sum = sum + fdiv(x * gg, longint'(1) << (GW-1));
      end
    end
    s = fdiv(sum, longint'(1) << sh);
    if (s > hi)      begin e.m = W'(hi); e.c = 1'b1; end
    else if (s < lo) begin e.m = W'(lo); e.c = 1'b1; end
    else             begin e.m = W'(s);  e.c = 1'b0; end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mixed_valid) begin
      valid_cnt++;
      check("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("mixed", mixed, mon_e.m);
        check("clip", clip, mon_e.c);
      end
    end
  end

  task automatic issue(input logic [NCH*W-1:0] d, input logic [NCH-1:0] a,
                       input logic [NCH*GW-1:0] g, input logic [2:0] sh, input bit push);
    @(negedge clk);
    ch_data = d; ch_active = a; ch_gain = g; master_shift = sh;
    sample_stb = 1'b1;
    if (push) sb_q.push_back(model(d, a, g, sh));
  endtask

  // One pass with busy-length and result-latency checks; the strobe is set on
  // negedge 0, so a result 9 edges after the accepting edge is seen on negedge NCH+2.
  task automatic run_pass(input logic [NCH*W-1:0] d, input logic [NCH-1:0] a,
                          input logic [NCH*GW-1:0] g, input logic [2:0] sh);
    int bc, vat;
    bc = 0; vat = -1;
    issue(d, a, g, sh, 1'b1);
    for (int i = 1; i <= NCH + 6; i++) begin
      @(negedge clk);
      if (i == 1) sample_stb = 1'b0;
      if (busy) bc++;
      if (mixed_valid && vat < 0) vat = i;
    end
    check("busy_cycles", bc, NCH + 1);
    check("valid_latency", vat, NCH + 2);
  endtask

  function automatic logic [NCH*W-1:0] fill_data(input logic [W-1:0] v);
    logic [NCH*W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [NCH*GW-1:0] fill_gain(input logic [GW-1:0] v);
    logic [NCH*GW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*GW +: GW] = v;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH*W-1:0]  d;
    logic [NCH-1:0]    a;
    logic [NCH*GW-1:0] g;
    int vc0, ones;
    logic [15:0] pw;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mixed", mixed, 0);
    check("rst_valid", mixed_valid, 0);
    check("rst_clip", clip, 0);
    check("rst_pwm", pwm_out, 0);
    rst_n = 1'b1;

    // 1000*8/8 + (-300*4/8) = 850
    d = '0; d[0 +: W] = 16'd1000; d[W +: W] = -16'sd300;
    g = '0; g[0 +: GW] = 4'd8; g[GW +: GW] = 4'd4;
    run_pass(d, 8'b0000_0011, g, 3'd0);

    // Reset in the third ACC cycle: pass abandoned, outputs cleared
    vc0 = valid_cnt;
    issue(fill_data(16'h1234), '1, fill_gain(4'd8), 3'd0, 1'b0);
    @(negedge clk); sample_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstacc_busy", busy, 0);
    check("rstacc_mixed", mixed, 0);
    check("rstacc_clip", clip, 0);
    check("rstacc_valid", mixed_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("pwm_after_reset", pwm_out, k % 2);
    end
    check("rstacc_no_valid", valid_cnt, vc0);

    run_pass(fill_data(16'h7FFF), '1, fill_gain(4'd15), 3'd0);
    run_pass(fill_data(16'h8000), '1, fill_gain(4'd15), 3'd0);
    run_pass(fill_data(16'h7FFF), '1, fill_gain(4'd8),  3'd3);

    d = '0; d[0 +: W] = 16'hFFFF; d[2*W +: W] = 16'd5000;
    g = '0; g[0 +: GW] = 4'd1; g[2*GW +: GW] = 4'd8;
    run_pass(d, 8'b0000_0001, g, 3'd0);

    for (int n = 0; n < 30; n++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        case ($urandom_range(0, 3))
          0:       d[ch*W +: W] = 16'h7FFF;
          1:       d[ch*W +: W] = 16'h8000;
          default: d[ch*W +: W] = W'($urandom);
        endcase
        g[ch*GW +: GW] = GW'($urandom);
      end
      a = NCH'($urandom);
      run_pass(d, a, g, 3'($urandom_range(0, 7)));
    end

    // Strobe while busy plus changed inputs: one pass, snapshot result
    vc0 = valid_cnt;
    d = fill_data(16'd3000);
    issue(d, '1, fill_gain(4'd3), 3'd1, 1'b1);
    @(negedge clk); sample_stb = 1'b0;
    @(negedge clk); ch_data = fill_data(16'h9000); sample_stb = 1'b1;
    @(negedge clk); sample_stb = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_strobe_one_pass", valid_cnt - vc0, 1);

    // Back-to-back strobes every 10 cycles
    vc0 = valid_cnt;
    for (int k = 0; k < 5; k++) begin
      for (int ch = 0; ch < NCH; ch++) d[ch*W +: W] = W'($urandom);
      issue(d, NCH'($urandom), fill_gain(GW'($urandom)), 3'($urandom_range(0, 7)), 1'b1);
      @(negedge clk); sample_stb = 1'b0;
      repeat (8) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("every10_valid_count", valid_cnt - vc0, 5);

    // Density 3/4 for mixed=0x4000
    d = '0; d[0 +: W] = 16'h4000;
    g = '0; g[0 +: GW] = 4'd8;
    run_pass(d, 8'b0000_0001, g, 3'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      pw[k] = pwm_out;
    end
    for (int j = 0; j <= 12; j++) begin
      ones = 0;
      for (int k = j; k < j + 4; k++) ones += int'(pw[k]);
      check("dsm_density_3of4", ones, 3);
    end

    run_pass(fill_data(16'h8000), '1, fill_gain(4'd15), 3'd0);
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ones += int'(pwm_out);
    end
    check("dsm_min_all_zero", ones, 0);

    repeat (12) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
